// File: rtl/seven_segment_decoder_if.sv
// Display-bus sample inputs and decoded frame outputs of the seven-segment readback monitor.
interface seven_segment_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    sample_en;
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    err_clr;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic                    frame_valid;
  logic                    pattern_err;
  logic                    sel_err;

  modport master (
    output sample_en, seg_in, dig_sel, err_clr,
    input  digits_out, frame_valid, pattern_err, sel_err
  );

  modport slave (
    input  sample_en, seg_in, dig_sel, err_clr,
    output digits_out, frame_valid, pattern_err, sel_err
  );
endinterface

// File: rtl/seven_segment_decoder.sv
// Recovers BCD digits from a multiplexed seven-segment bus: debounces each
// {segments, digit select} pattern and publishes a full frame atomically.
module seven_segment_decoder #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic clk,
  input  logic reset,
  seven_segment_decoder_if.slave bus
);
  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] STABLE_V = CW'(STABLE_CNT);

  // Returns {unrecognised, code}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   decode = 5'h00;
      7'h03:   decode = 5'h01;
      7'h6D:   decode = 5'h02;
      7'h67:   decode = 5'h03;
      7'h53:   decode = 5'h04;
      7'h76:   decode = 5'h05;
      7'h7E:   decode = 5'h06;
      7'h23:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h77:   decode = 5'h09;
      7'h00:   decode = 5'h0F;
      7'h40:   decode = 5'h0E;
      default: decode = 5'h1E;
    endcase
  endfunction

  logic [6:0]            prev_seg, prev_seg_nxt;
  logic [NUM_DIGITS-1:0] prev_sel, prev_sel_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, cnt_new;
  logic [DW-1:0]         shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0] mask, mask_nxt;
  logic [DW-1:0]         digits_q, digits_nxt;
  logic                  frame_q, frame_nxt;
  logic                  perr_q, perr_nxt, perr_set;
  logic                  serr_q, serr_nxt, serr_set;
  logic                  same, commit, onehot, multi;
  logic [4:0]            dec;

  assign same    = (bus.seg_in == prev_seg) && (bus.dig_sel == prev_sel);
  assign cnt_new = same ? ((cnt == STABLE_V) ? cnt : cnt + CW'(1)) : CW'(1);
  // A saturated run of identical samples must not commit again.
  assign commit  = bus.sample_en && (cnt_new == STABLE_V) && !(same && (cnt == STABLE_V));
  assign onehot  = $onehot(bus.dig_sel);
  assign multi   = (bus.dig_sel != '0) && !onehot;
  assign dec     = decode(bus.seg_in);

  always_comb begin
    prev_seg_nxt = prev_seg;
    prev_sel_nxt = prev_sel;
    cnt_nxt      = cnt;
    shadow_nxt   = shadow;
    mask_nxt     = mask;
    digits_nxt   = digits_q;
    frame_nxt    = 1'b0;
    perr_set     = 1'b0;
    serr_set     = 1'b0;
    if (bus.sample_en) begin
      prev_seg_nxt = bus.seg_in;
      prev_sel_nxt = bus.dig_sel;
      cnt_nxt      = cnt_new;
    end
    if (commit && onehot) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (bus.dig_sel[i]) shadow_nxt[4*i +: 4] = dec[3:0];
      end
      mask_nxt = mask | bus.dig_sel;
      perr_set = dec[4];
      if (&mask_nxt) begin
        digits_nxt = shadow_nxt;
        frame_nxt  = 1'b1;
        mask_nxt   = '0;
      end
    end else if (commit && multi) begin
      serr_set = 1'b1;
    end
    perr_nxt = (perr_q && !bus.err_clr) || perr_set;
    serr_nxt = (serr_q && !bus.err_clr) || serr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_seg <= '0;
      prev_sel <= '0;
      cnt      <= '0;
      shadow   <= '1;
      mask     <= '0;
      digits_q <= '1;
      frame_q  <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      prev_seg <= prev_seg_nxt;
      prev_sel <= prev_sel_nxt;
      cnt      <= cnt_nxt;
      shadow   <= shadow_nxt;
      mask     <= mask_nxt;
      digits_q <= digits_nxt;
      frame_q  <= frame_nxt;
      perr_q   <= perr_nxt;
      serr_q   <= serr_nxt;
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.frame_valid = frame_q;
  assign bus.pattern_err = perr_q;
  assign bus.sel_err     = serr_q;
endmodule
